// File: rtl/spm_seq.sv
// rtl/spm_seq.sv - sequencer for the bit-serial serial-parallel multiplier
// Optional build macro SPM_SEQ_SIGNED_EN: sign-extend the serial multiplier (two's-complement y).
module spm_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x_in,
    input  logic [WIDTH-1:0]   y_in,
    output logic [WIDTH-1:0]   x_arr,
    output logic               y_bit,
    output logic               arr_clr,
    input  logic               p_bit,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(PW) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] y_reg;
    logic             y_fill;
    logic             accept;
    logic             last_bit;

    assign accept   = in_valid & in_ready;
    assign last_bit = (cnt == CW'(PW - 1));

`ifdef SPM_SEQ_SIGNED_EN
    // Arithmetic shift: the MSB re-fills itself, so the sign bit persists for k >= WIDTH.
    assign y_fill = y_reg[WIDTH-1];
`else
    assign y_fill = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        arr_clr   = 1'b0;
        y_bit     = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                arr_clr   = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                y_bit = y_reg[0];
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_arr   <= '0;
            y_reg   <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            if (accept) begin
                x_arr <= x_in;
                y_reg <= y_in;
            end
            case (state)
                CLEAR: begin
                    cnt     <= '0;
                    product <= '0;
                end
                SHIFT: begin
                    // After PW shifts the bit returned in cycle k lands in product[k].
                    y_reg   <= {y_fill, y_reg[WIDTH-1:1]};
                    product <= {p_bit, product[PW-1:1]};
                    cnt     <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
